// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, FSM state encoding, baud divider helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK,
        ST_MARK
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// Word handshake between a byte/word source and the framed UART transmitter.
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = !clr && (cnt_q == TC);
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Parametrised framed UART transmitter with valid/ready input.
// Optional line-break generation is built when UART_TX_BREAK_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | line at mark, ready for a word
// ST_START  | start bit (0)
// ST_DATA   | payload bits, LSB first
// ST_PARITY | parity bit (only when PARITY != none)
// ST_STOP   | STOP_BITS stop bits (1)
// ST_BREAK  | line held low while tx_break is high
// ST_MARK   | one bit time of mark after a break
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic clk,
    input  logic rst,
    uart_tx_framed_if.slave s_if,
`ifdef UART_TX_BREAK_EN
    input  logic tx_break,
`endif
    output logic tx,
    output logic busy,
    output logic done
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [3:0] LAST_DATA    = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP    = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_framed: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 baud_clr;
    logic                 break_req;
    logic                 xfer;

`ifdef UART_TX_BREAK_EN
    assign break_req = tx_break;
`else
    assign break_req = 1'b0;
`endif

    // A pending break takes the idle slot, so the word stays with the source.
    assign s_if.in_ready = (state_q == ST_IDLE) && !rst && !break_req;
    assign xfer          = s_if.in_valid && s_if.in_ready;
    assign baud_clr      = (state_q == ST_IDLE) || (state_q == ST_BREAK);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d   = ST_START;
                    shreg_d   = s_if.in_data;
                    par_d     = (PARITY == PAR_ODD) ? ~^s_if.in_data : ^s_if.in_data;
                    bit_idx_d = '0;
                end
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = ST_BREAK;
                end
`endif
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (!break_req) begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is registered, so it follows the state being entered.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_q;
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Randomised bench for uart_tx_framed: three configurations checked each cycle against a frame-level line model.
module tb_uart_tx_framed;
    import uart_pkg::*;

    localparam int NDUT = 3;
    localparam int CPB   [NDUT] = '{16, 16, 3};
    localparam int DBITS [NDUT] = '{8, 7, 7};
    localparam int PAR   [NDUT] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
    localparam int STOPB [NDUT] = '{1, 2, 1};
    localparam int GAP   [NDUT] = '{161, 177, 31};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_framed_if #(.DATA_BITS(8)) if0 ();
    uart_tx_framed_if #(.DATA_BITS(7)) if1 ();
    uart_tx_framed_if #(.DATA_BITS(7)) if2 ();

    logic [NDUT-1:0] tx_o, busy_o, done_o;
`ifdef UART_TX_BREAK_EN
    logic brk = 1'b0;
    int   bst  [NDUT];
    int   bcnt [NDUT];
`endif

    uart_tx_framed #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .s_if(if0),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    uart_tx_framed #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .s_if(if1),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    uart_tx_framed #(.CLK_FREQ_HZ(10), .BAUD_RATE(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .s_if(if2),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]));

    int         n_checks = 0;
    int         n_errs   = 0;
    int         cyc      = 0;
    bit         v_cur  [NDUT];
    logic [8:0] d_cur  [NDUT];
    bit         act    [NDUT];
    int         pos    [NDUT];
    bit         mdone  [NDUT];
    bit         fbits  [NDUT][12];
    int         flen   [NDUT];
    int         nacc   [NDUT];
    bit         rec_falls = 1'b0;
    int         falls  [NDUT][$];
    logic       prev_tx[NDUT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic dut_ready(input int k);
        case (k)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    task automatic apply();
        if0.in_valid = v_cur[0];
        if0.in_data  = d_cur[0][7:0];
        if1.in_valid = v_cur[1];
        if1.in_data  = d_cur[1][6:0];
        if2.in_valid = v_cur[2];
        if2.in_data  = d_cur[2][6:0];
    endtask

    // Expected line levels for one frame: start, data LSB first, parity, stops.
    task automatic build_frame(input int k, input logic [8:0] d);
        logic [8:0] dm;
        int         ones;
        int         n;
        dm   = d & 9'((1 << DBITS[k]) - 1);
        ones = $countones(dm);
        fbits[k][0] = 1'b0;
        n = 1;
        for (int i = 0; i < DBITS[k]; i++) begin
            fbits[k][n] = dm[i];
            n = n + 1;
        end
        if (PAR[k] == PAR_ODD) begin
            fbits[k][n] = (ones % 2 == 0);
            n = n + 1;
        end else if (PAR[k] == PAR_EVEN) begin
            fbits[k][n] = (ones % 2 == 1);
            n = n + 1;
        end
        for (int s = 0; s < STOPB[k]; s++) begin
            fbits[k][n] = 1'b1;
            n = n + 1;
        end
        flen[k] = n * CPB[k];
    endtask

    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            mdone[k] = 1'b0;
            if (rst) begin
                act[k] = 1'b0;
`ifdef UART_TX_BREAK_EN
                bst[k] = 0;
`endif
            end else if (act[k]) begin
                pos[k]++;
                if (pos[k] == flen[k]) begin
                    act[k]   = 1'b0;
                    mdone[k] = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
            end else if (bst[k] == 1) begin
                if (!brk) begin
                    bst[k]  = 2;
                    bcnt[k] = 0;
                end
            end else if (bst[k] == 2) begin
                bcnt[k]++;
                if (bcnt[k] == CPB[k]) bst[k] = 0;
`endif
            end else begin
`ifdef UART_TX_BREAK_EN
                if (brk) bst[k] = 1;
                else
`endif
                if (v_cur[k]) begin
                    act[k] = 1'b1;
                    pos[k] = 0;
                    build_frame(k, d_cur[k]);
                    nacc[k]++;
                end
            end
        end
    endtask

    task automatic model_check();
        logic e_tx, e_busy, e_done, e_rdy;
        for (int k = 0; k < NDUT; k++) begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_done = mdone[k];
            e_rdy  = !rst;
`ifdef UART_TX_BREAK_EN
            e_rdy  = !rst && !brk;
            if (bst[k] != 0) begin
                e_tx   = (bst[k] == 2);
                e_busy = 1'b1;
                e_done = 1'b0;
                e_rdy  = 1'b0;
            end
`endif
            if (act[k]) begin
                e_tx   = fbits[k][pos[k] / CPB[k]];
                e_busy = 1'b1;
                e_done = 1'b0;
                e_rdy  = 1'b0;
            end
            check($sformatf("d%0d.tx", k), tx_o[k], e_tx);
            check($sformatf("d%0d.busy", k), busy_o[k], e_busy);
            check($sformatf("d%0d.done", k), done_o[k], e_done);
            check($sformatf("d%0d.in_ready", k), dut_ready(k), e_rdy);
            if (rec_falls && prev_tx[k] === 1'b1 && tx_o[k] === 1'b0) falls[k].push_back(cyc);
            prev_tx[k] = tx_o[k];
        end
    endtask

    task automatic tick();
        apply();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        model_check();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_all(input bit v, input logic [8:0] d);
        for (int k = 0; k < NDUT; k++) begin
            v_cur[k] = v;
            d_cur[k] = d;
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            act[k] = 1'b0; pos[k] = 0; mdone[k] = 1'b0; flen[k] = 0; nacc[k] = 0; prev_tx[k] = 1'b1;
`ifdef UART_TX_BREAK_EN
            bst[k] = 0; bcnt[k] = 0;
`endif
        end
        set_all(1'b0, 9'h000);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2);

        // single 0x41 frame on every configuration
        set_all(1'b1, 9'h041);
        tick();
        set_all(1'b0, 9'h041);
        run(200);

        // back-to-back: 0x00 then all-ones with valid held high
        for (int k = 0; k < NDUT; k++) begin
            nacc[k] = 0;
            falls[k].delete();
        end
        rec_falls = 1'b1;
        repeat (400) begin
            for (int k = 0; k < NDUT; k++) begin
                v_cur[k] = 1'b1;
                d_cur[k] = (nacc[k] == 0) ? 9'h000 : 9'h1FF;
            end
            tick();
        end
        set_all(1'b0, 9'h000);
        run(200);
        rec_falls = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("d%0d.start_gap", k),
                  (falls[k].size() >= 2) ? 32'(falls[k][1] - falls[k][0]) : 32'hFFFF_FFFF, GAP[k]);
        end

        // reset 40 cycles into a frame, then a clean frame
        set_all(1'b1, 9'($urandom));
        tick();
        set_all(1'b0, 9'h000);
        run(40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_all(1'b1, 9'h05A);
        tick();
        set_all(1'b0, 9'h000);
        run(200);

        // random traffic: valid and data churn while busy, rare resets
        repeat (3000) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < NDUT; k++) begin
                v_cur[k] = 1'($urandom_range(0, 1));
                d_cur[k] = 9'($urandom);
            end
`ifdef UART_TX_BREAK_EN
            if ($urandom_range(0, 63) == 0) brk = ~brk;
`endif
            tick();
        end
        rst = 1'b0;
        set_all(1'b0, 9'h000);
`ifdef UART_TX_BREAK_EN
        brk = 1'b0;
`endif
        run(200);

`ifdef UART_TX_BREAK_EN
        // break with a pending word: break first, then mark, then the word
        for (int k = 0; k < NDUT; k++) nacc[k] = 0;
        brk = 1'b1;
        set_all(1'b1, 9'h033);
        run(50);
        brk = 1'b0;
        repeat (40) begin
            for (int k = 0; k < NDUT; k++) v_cur[k] = (nacc[k] == 0);
            tick();
        end
        set_all(1'b0, 9'h000);
        run(200);
        for (int k = 0; k < NDUT; k++) check($sformatf("d%0d.break_accept", k), nacc[k], 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
